clk_ratio_monitor: RTL
======================

# clk_ratio_monitor

Fast-domain checker that consumes a divided clock signal, such as the output of the team's divide-by-N clock generators, as an asynchronous data input. It measures the rising-edge-to-rising-edge period in `clk` cycles and reports each measurement. It declares lock after a run of periods equal to the expected ratio, and flags mismatches and loss of clock. It sits beside each clock divider so the access-control logic can confirm the slow clock is alive and correct before using it.

## Interface
- `CNT_W`, 8: width of the period counter and `period` output; maximum measurable period is 2^CNT_W−1.
- `EXPECTED`, 5: expected period in `clk` cycles; range 2..2^CNT_W−2.
- `LOCK_COUNT`, 4: number of consecutive matching periods required to assert `locked`; range 1..15.
- `clk`  in  1  fast reference clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `sig_in`  in  1  divided clock under test; asynchronous to `clk`.
- `period`  out  CNT_W  last measured period, in `clk` cycles.
- `period_valid`  out  1  one-cycle pulse when `period` is updated.
- `locked`  out  1  high while the last LOCK_COUNT periods all equalled EXPECTED.
- `err`  out  1  one-cycle pulse on period mismatch or timeout.

## Operation
- Synchronizer: two flops `s1`, `s2` plus history flop `s3`; `rise = s2 & ~s3`. All three reset to 0.
  - If `sig_in` is high at reset release, a rise is detected. This is harmless because it only arms measurement.
- Internal registers: state, `cnt` (CNT_W bits), and `match_cnt` (4 bits).
- State machine:
  - IDLE: `cnt` = 0. On `rise`: `cnt` <= 1, go to MEASURE, no `period_valid`.
  - MEASURE with `rise`:
    - `period` <= `cnt`, `period_valid` <= 1, `cnt` <= 1.
    - Match (`cnt` == EXPECTED): `match_cnt` <= min(`match_cnt`+1, LOCK_COUNT). `locked` <= 1 when the new `match_cnt` == LOCK_COUNT.
    - Mismatch: `err` <= 1, `match_cnt` <= 0, `locked` <= 0.
  - MEASURE, no `rise`, `cnt` < 2^CNT_W−1: `cnt` <= `cnt`+1.
  - MEASURE, no `rise`, `cnt` == 2^CNT_W−1 (timeout):
    - `err` <= 1, `locked` <= 0, `match_cnt` <= 0, `cnt` <= 0, go to IDLE.
    - `period` holds its value; no `period_valid`.
- A rise on the same cycle that `cnt` reaches its maximum is treated as a measurement, not a timeout (`period` = 2^CNT_W−1, mismatch).
- Only rising edges are measured. Duty cycle is ignored, so 2-high/3-low and 3-high/2-low waveforms both measure 5.
- `locked` stays high across further matching periods; `match_cnt` saturates.

## Timing
- Reset values: `period` = 0, `period_valid` = 0, `locked` = 0, `err` = 0, state = IDLE, `cnt` = 0, `match_cnt` = 0.
- `rst` dominates every other event on the same edge. Reset mid-measurement discards the partial count, and `locked` drops on the next edge.
- Edge-detect latency: `sig_in` sampled high at edge k gives `rise` high between edges k+1 and k+2. Registered outputs update at edge k+2.
- `period_valid` and `err` are single-cycle pulses and are never held. On a mismatch both pulse on the same edge.
- With a steady period-P input, the first `period_valid` appears one period after the first detected rise. `locked` rises on the LOCK_COUNT-th `period_valid` with `period` == EXPECTED.
- The synchronizer may shift a single rise by ±1 cycle for asynchronous inputs. A jittered measurement (EXPECTED±1) counts as a mismatch.

## Test plan
- Reset check: assert `rst` 3 cycles with `sig_in` toggling → all outputs 0 throughout; no pulses for 2 cycles after release.
- Lock at defaults: drive `sig_in` synchronous, 2 cycles high / 3 low → `period_valid` every 5 cycles with `period` = 5, `err` never pulses, `locked` high on the 4th `period_valid` and stays high.
- Mismatch after lock: once locked, stretch one low phase to 4 cycles (period 6) → `period` = 6, `err` and `period_valid` pulse on the same cycle, `locked` drops on that edge and re-asserts after 4 more period-5 measurements.
- Timeout: CNT_W = 4, lock on period 5, then hold `sig_in` low → `err` pulses once when `cnt` hits 15, `locked` = 0, `period` stays 5, and there are no further pulses while low.
- Recovery from timeout: resume the period-5 input → first rise produces no `period_valid`; the next rise gives `period` = 5.
- Reset mid-operation: assert `rst` for 1 cycle while locked, mid-period → `locked` = 0 and `period` = 0 after the edge. After release, the measurement sequence restarts from IDLE and relocks after 4 matches.

Source files
------------

// File: rtl/clk_ratio_monitor.sv
// clk_ratio_monitor
// Measures the rising-edge period of an asynchronous divided clock in
// fast-clock cycles. It reports each period, declares lock after a run of
// periods equal to EXPECTED, and pulses err on a mismatch or when the
// input stops toggling.
module clk_ratio_monitor #(
  parameter int CNT_W      = 8,
  parameter int EXPECTED   = 5,
  parameter int LOCK_COUNT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             err
);

  // Longest period the counter can represent. Reaching it without an edge
  // means the input clock is considered lost.
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] EXP_VAL  = CNT_W'(EXPECTED);
  localparam logic [3:0]       LOCK_VAL = 4'(LOCK_COUNT);

  typedef enum logic {
    IDLE,
    MEASURE
  } state_t;

  state_t           state;
  logic             s1;
  logic             s2;
  logic             s3;
  logic             rise;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       match_cnt;
  logic [3:0]       match_next;

  // Two-flop synchronizer for the asynchronous input, plus one history flop
  // used for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

  // The match run saturates at LOCK_COUNT, so lock holds across further
  // matching periods without the 4-bit counter wrapping.
  assign match_next = (match_cnt >= LOCK_VAL) ? LOCK_VAL : match_cnt + 4'd1;

  // Measurement FSM. All outputs are registered here. period_valid and err
  // fall back to zero on every cycle that does not explicitly pulse them.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      match_cnt    <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      err          <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      err          <= 1'b0;
      case (state)
        IDLE: begin
          // The first rise only arms the measurement; no period exists yet.
          cnt <= '0;
          if (rise) begin
            cnt   <= CNT_W'(1);
            state <= MEASURE;
          end
        end
        MEASURE: begin
          if (rise) begin
            // A rise wins over a timeout on the same cycle, so a period of
            // exactly CNT_MAX is still reported (as a mismatch).
            period       <= cnt;
            period_valid <= 1'b1;
            cnt          <= CNT_W'(1);
            if (cnt == EXP_VAL) begin
              match_cnt <= match_next;
              if (match_next == LOCK_VAL) begin
                locked <= 1'b1;
              end
            end else begin
              err       <= 1'b1;
              match_cnt <= '0;
              locked    <= 1'b0;
            end
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_W'(1);
          end else begin
            // Input lost: drop lock, keep the last period, and re-arm from IDLE.
            err       <= 1'b1;
            locked    <= 1'b0;
            match_cnt <= '0;
            cnt       <= '0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
